// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: memory read port plus the decoder-side valid/ready
// handshake, jump redirect and halt.
interface fetch_unit_if;
   logic [15:0] mem_address;
   logic        mem_enable;
   logic        mem_load;
   logic [15:0] mem_data;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        jump_valid;
   logic [15:0] jump_addr;
   logic        halt;

   modport master (
      output mem_address, mem_enable, mem_load, instr, instr_pc, instr_valid,
      input  mem_data, instr_ready, jump_valid, jump_addr, halt
   );

   modport slave (
      input  mem_address, mem_enable, mem_load, instr, instr_pc, instr_valid,
      output mem_data, instr_ready, jump_valid, jump_addr, halt
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one pipelined read per cycle into a small in-order
// buffer of {word, pc}, with jump flush and halt.
module fetch_unit #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000,
   parameter int unsigned DEPTH        = 2
) (
   input  logic          clk_i,
   input  logic          reset_i,
   fetch_unit_if.master  fu
);
   localparam int unsigned CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   logic [15:0]   pc_q, pc_d;
   logic [15:0]   pend_pc_q, pend_pc_d;
   logic          pend_q, pend_d;
   logic [15:0]   word_q [DEPTH];
   logic [15:0]   word_d [DEPTH];
   logic [15:0]   wpc_q  [DEPTH];
   logic [15:0]   wpc_d  [DEPTH];
   logic [CW-1:0] count_q, count_d, wr_idx;
   logic [CW:0]   occ;
   logic          pop, push, issue;

   assign pop    = (count_q != '0) & fu.instr_ready;
   assign push   = pend_q & ~fu.jump_valid;
   // Occupancy after this cycle's pop plus the read already in flight.
   assign occ    = {1'b0, count_q} + (CW + 1)'(pend_q) - (CW + 1)'(pop);
   assign issue  = ~reset_i & ~fu.halt & ~fu.jump_valid & (occ < DEPTH_W);
   assign wr_idx = count_q - CW'(pop);

   assign fu.mem_address = pc_q;
   assign fu.mem_enable  = issue;
   assign fu.mem_load    = 1'b0;
   assign fu.instr       = word_q[0];
   assign fu.instr_pc    = wpc_q[0];
   assign fu.instr_valid = (count_q != '0);

   always_comb begin
      pc_d      = pc_q;
      pend_d    = 1'b0;
      pend_pc_d = pend_pc_q;
      word_d    = word_q;
      wpc_d     = wpc_q;
      count_d   = count_q + CW'(push) - CW'(pop);

      if (issue) begin
         pc_d      = pc_q + 16'd1;
         pend_d    = 1'b1;
         pend_pc_d = pc_q;
      end

      // Head lives at index 0: shift on pop, then write at the post-pop tail.
      if (pop) begin
         for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            word_d[i] = word_q[i + 1];
            wpc_d[i]  = wpc_q[i + 1];
         end
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (push && (CW'(i) == wr_idx)) begin
            word_d[i] = fu.mem_data;
            wpc_d[i]  = pend_pc_q;
         end
      end

      if (fu.jump_valid) begin
         pc_d    = fu.jump_addr;
         pend_d  = 1'b0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pc_q      <= RESET_VECTOR;
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
         count_q   <= '0;
         word_q    <= '{default: '0};
         wpc_q     <= '{default: '0};
      end else begin
         pc_q      <= pc_d;
         pend_q    <= pend_d;
         pend_pc_q <= pend_pc_d;
         count_q   <= count_d;
         word_q    <= word_d;
         wpc_q     <= wpc_d;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed per-cycle vector bench for fetch_unit (DEPTH=2), with a second
// instance at RESET_VECTOR=FFFE for the PC wrap.
module tb_fetch_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_unit_if bus ();
   fetch_unit_if wbus ();

   fetch_unit #(.RESET_VECTOR(16'h0010), .DEPTH(2)) dut (
      .clk_i(clk), .reset_i(rst), .fu(bus)
   );
   fetch_unit #(.RESET_VECTOR(16'hFFFE), .DEPTH(2)) dut_w (
      .clk_i(clk), .reset_i(rst), .fu(wbus)
   );

   // Memory: word[a] = a ^ A5A5, one-cycle read latency.
   always @(posedge clk) begin
      if (bus.mem_enable && !bus.mem_load)   bus.mem_data  <= bus.mem_address ^ 16'hA5A5;
      if (wbus.mem_enable && !wbus.mem_load) wbus.mem_data <= wbus.mem_address ^ 16'hA5A5;
   end

   typedef struct {
      logic        rst, rdy, hlt, jv;
      logic [15:0] ja;
      logic        en;
      logic [15:0] addr;
      logic        vld;
      logic [15:0] ipc;
      logic        zero;
      logic        wchk;
      logic [15:0] wpc;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   task automatic add(input logic r, input logic rd, input logic h, input logic j,
                      input logic [15:0] ja, input logic en, input logic [15:0] addr,
                      input logic v, input logic [15:0] ipc, input logic z,
                      input logic wc, input logic [15:0] wpc);
      vec_t t;
      t.rst = r; t.rdy = rd; t.hlt = h; t.jv = j; t.ja = ja;
      t.en = en; t.addr = addr; t.vld = v; t.ipc = ipc; t.zero = z;
      t.wchk = wc; t.wpc = wpc;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input int cyc, input logic [15:0] act,
                        input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   initial begin
      bus.instr_ready  = 1'b0; bus.jump_valid  = 1'b0; bus.jump_addr  = '0; bus.halt  = 1'b0;
      wbus.instr_ready = 1'b1; wbus.jump_valid = 1'b0; wbus.jump_addr = '0; wbus.halt = 1'b0;

      // rst rdy hlt jv ja | en addr vld ipc zero | wchk wpc
      add(0,1,0,0,16'h0, 1,16'h0010, 0,16'h0,    1, 0,16'h0);     // c0
      add(0,1,0,0,16'h0, 1,16'h0011, 0,16'h0,    0, 0,16'h0);     // c1
      add(0,1,0,0,16'h0, 1,16'h0012, 1,16'h0010, 0, 1,16'hFFFE);  // c2
      add(0,1,0,0,16'h0, 1,16'h0013, 1,16'h0011, 0, 1,16'hFFFF);
      add(0,1,0,0,16'h0, 1,16'h0014, 1,16'h0012, 0, 1,16'h0000);
      add(0,1,0,0,16'h0, 1,16'h0015, 1,16'h0013, 0, 1,16'h0001);
      for (int k = 0; k < 10; k++)                                 // c6..c15 stall
         add(0,0,0,0,16'h0, 0,16'h0016, 1,16'h0014, 0, 0,16'h0);
      add(0,1,0,0,16'h0, 1,16'h0016, 1,16'h0014, 0, 0,16'h0);     // c16 release
      add(0,1,0,0,16'h0, 1,16'h0017, 1,16'h0015, 0, 0,16'h0);
      add(0,1,0,0,16'h0, 1,16'h0018, 1,16'h0016, 0, 0,16'h0);
      add(0,1,0,0,16'h0, 1,16'h0019, 1,16'h0017, 0, 0,16'h0);
      add(0,0,0,0,16'h0, 0,16'h001A, 1,16'h0018, 0, 0,16'h0);     // c20 fill
      add(0,0,0,1,16'h0200, 0,16'h001A, 1,16'h0018, 0, 0,16'h0);  // c21 jump
      add(0,1,0,0,16'h0, 1,16'h0200, 0,16'h0,    0, 0,16'h0);
      add(0,1,0,0,16'h0, 1,16'h0201, 0,16'h0,    0, 0,16'h0);
      add(0,1,0,0,16'h0, 1,16'h0202, 1,16'h0200, 0, 0,16'h0);     // c24 = J+3
      add(0,1,1,0,16'h0, 0,16'h0203, 1,16'h0201, 0, 0,16'h0);     // c25 halt
      add(0,1,1,0,16'h0, 0,16'h0203, 1,16'h0202, 0, 0,16'h0);
      for (int k = 0; k < 3; k++)
         add(0,1,1,0,16'h0, 0,16'h0203, 0,16'h0, 0, 0,16'h0);
      add(0,1,0,0,16'h0, 1,16'h0203, 0,16'h0,    0, 0,16'h0);     // c30 resume
      add(0,1,0,0,16'h0, 1,16'h0204, 0,16'h0,    0, 0,16'h0);
      add(0,1,0,0,16'h0, 1,16'h0205, 1,16'h0203, 0, 0,16'h0);
      add(0,0,0,0,16'h0, 0,16'h0206, 1,16'h0204, 0, 0,16'h0);     // c33
      add(1,0,0,0,16'h0, 0,16'h0206, 1,16'h0204, 0, 0,16'h0);     // c34 reset
      add(0,1,0,0,16'h0, 1,16'h0010, 0,16'h0,    1, 0,16'h0);     // c35 restart
      add(0,1,0,0,16'h0, 1,16'h0011, 0,16'h0,    0, 0,16'h0);
      add(0,1,0,0,16'h0, 1,16'h0012, 1,16'h0010, 0, 0,16'h0);

      // Reset sequence: two cycles, check state after the first reset edge.
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_en",    -1, {15'h0, bus.mem_enable}, 16'h0);
      check("rst_load",  -1, {15'h0, bus.mem_load},   16'h0);
      check("rst_addr",  -1, bus.mem_address,         16'h0010);
      check("rst_valid", -1, {15'h0, bus.instr_valid}, 16'h0);
      check("rst_instr", -1, bus.instr,               16'h0);
      check("rst_ipc",   -1, bus.instr_pc,            16'h0);
      check("rst_waddr", -1, wbus.mem_address,        16'hFFFE);
      @(posedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst             = vecs[i].rst;
         bus.instr_ready = vecs[i].rdy;
         bus.halt        = vecs[i].hlt;
         bus.jump_valid  = vecs[i].jv;
         bus.jump_addr   = vecs[i].ja;
         #1;
         check("mem_enable",  i, {15'h0, bus.mem_enable},  {15'h0, vecs[i].en});
         check("mem_address", i, bus.mem_address,          vecs[i].addr);
         check("mem_load",    i, {15'h0, bus.mem_load},    16'h0);
         check("instr_valid", i, {15'h0, bus.instr_valid}, {15'h0, vecs[i].vld});
         if (vecs[i].vld) begin
            check("instr_pc", i, bus.instr_pc, vecs[i].ipc);
            check("instr",    i, bus.instr,    vecs[i].ipc ^ 16'hA5A5);
         end
         if (vecs[i].zero) begin
            check("instr_zero",    i, bus.instr,    16'h0);
            check("instr_pc_zero", i, bus.instr_pc, 16'h0);
         end
         if (vecs[i].wchk) begin
            check("wrap_valid", i, {15'h0, wbus.instr_valid}, 16'h1);
            check("wrap_pc",    i, wbus.instr_pc, vecs[i].wpc);
            check("wrap_instr", i, wbus.instr,    vecs[i].wpc ^ 16'hA5A5);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
